// File: rtl/fv_pkg.sv
// Shared types for the formal-environment scoreboard: FSM state encoding and
// the bit positions of the sticky error-flag vector.
package fv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2,
    DONE = 2'd3
  } sb_state_t;

  localparam int ERR_MISMATCH  = 0;
  localparam int ERR_UNDERFLOW = 1;
  localparam int ERR_OVERFLOW  = 2;
  localparam int ERR_LEFTOVER  = 3;
  localparam int ERR_W         = 4;

endpackage

// File: rtl/fv_scoreboard_if.sv
// Channel between the scoreboard and its environment: model FIFO push/pop
// side plus the observed DUT output srdy/drdy channel.
interface fv_scoreboard_if #(
  parameter int width = 8
);
  logic             push;
  logic [width-1:0] exp_data;
  logic             exp_valid;
  logic             exp_pop;
  logic             o_srdy;
  logic             o_drdy;
  logic [width-1:0] o_data;

  modport master (
    output push, exp_data, exp_valid, o_srdy, o_drdy, o_data,
    input  exp_pop
  );

  modport slave (
    input  push, exp_data, exp_valid, o_srdy, o_drdy, o_data,
    output exp_pop
  );
endinterface

// File: rtl/fv_sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module fv_sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [width-1:0] count_o
);

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  logic [width-1:0] count_q;
  logic [width-1:0] count_d;

  // Next count: increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {width{1'b1}})) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {width{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fv_scoreboard.sv
// Scoreboard downstream of the model FIFO: pops on every DUT transfer, compares
// data against the FIFO head, tracks occupancy and raises sticky error flags.
module fv_scoreboard
  import fv_pkg::*;
#(
  parameter int width     = 8,
  parameter int depth     = 8,
  parameter int cnt_width = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  fv_scoreboard_if.slave             sb,
  input  logic                       end_of_test,
  output logic [$clog2(depth+1)-1:0] occupancy,
  output logic [cnt_width-1:0]       xfer_count,
  output logic [cnt_width-1:0]       match_count,
  output logic                       err_mismatch,
  output logic                       err_underflow,
  output logic                       err_overflow,
  output logic                       err_leftover,
  output logic                       fail,
  output logic                       done
);

  localparam int OCC_W = $clog2(depth+1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(depth);
  localparam logic [OCC_W-1:0] OCC_ONE   = {{(OCC_W-1){1'b0}}, 1'b1};

  logic             xfer_s, have_s, pop_s, data_eq_s, activity_s, any_err_s;
  logic [width-1:0] data_diff_s;
  logic [ERR_W-1:0] err_set_s, err_q, err_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  sb_state_t        state_q, state_d;

  // Transfer decode and per-cycle error detection.
  always_comb begin
    xfer_s      = sb.o_srdy & sb.o_drdy;
    have_s      = (occ_q != {OCC_W{1'b0}});
    pop_s       = xfer_s & have_s;
    data_diff_s = sb.o_data ^ sb.exp_data;
    data_eq_s   = (data_diff_s == {width{1'b0}});
    activity_s  = sb.push | xfer_s;
    err_set_s   = {ERR_W{1'b0}};
    // FIFO's own valid is only trusted below depth, where full/empty is unambiguous.
    err_set_s[ERR_MISMATCH]  = (pop_s & ~data_eq_s) |
                               ((occ_q < DEPTH_OCC) & (sb.exp_valid != have_s));
    err_set_s[ERR_UNDERFLOW] = xfer_s & ~have_s;
    err_set_s[ERR_OVERFLOW]  = sb.push & ~pop_s & (occ_q == DEPTH_OCC);
    err_set_s[ERR_LEFTOVER]  = end_of_test & have_s;
    any_err_s   = |err_set_s;
    err_d       = err_q | err_set_s;
  end

  assign sb.exp_pop = pop_s & reset;

  // Occupancy next state; saturates at depth on overflow.
  always_comb begin
    occ_d = occ_q;
    case ({sb.push, pop_s})
      2'b10: begin
        if (occ_q == DEPTH_OCC) occ_d = occ_q;
        else                    occ_d = occ_q + OCC_ONE;
      end
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Occupancy and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= {OCC_W{1'b0}};
      err_q <= {ERR_W{1'b0}};
    end else begin
      occ_q <= occ_d;
      err_q <= err_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: any error wins over end_of_test.
  always_comb begin
    state_d = state_q;
    if ((state_q != FAIL) && any_err_s) begin
      state_d = FAIL;
    end else begin
      case (state_q)
        IDLE: begin
          if (end_of_test)     state_d = DONE;
          else if (activity_s) state_d = RUN;
          else                 state_d = IDLE;
        end
        RUN: begin
          if (end_of_test) state_d = DONE;
          else             state_d = RUN;
        end
        DONE: begin
          if (activity_s) state_d = RUN;
          else            state_d = DONE;
        end
        FAIL:    state_d = FAIL;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and status outputs.
  always_comb begin
    done          = (state_q == DONE);
    fail          = (state_q == FAIL);
    occupancy     = occ_q;
    err_mismatch  = err_q[ERR_MISMATCH];
    err_underflow = err_q[ERR_UNDERFLOW];
    err_overflow  = err_q[ERR_OVERFLOW];
    err_leftover  = err_q[ERR_LEFTOVER];
  end

  fv_sat_counter #(.width(cnt_width)) u_xfer_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (xfer_s),
    .count_o(xfer_count)
  );

  fv_sat_counter #(.width(cnt_width)) u_match_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (pop_s & data_eq_s),
    .count_o(match_count)
  );

endmodule
